apb2_burst_master: RTL
======================

Name: apb2_burst_master

Overview:
- Synthesizable APB2 initiator that turns single-command byte bursts into sequential APB2 transfers on consecutive addresses.
- Lets on-FPGA logic (test sequencers, control FSMs) drive the existing APB2 peripheral slaves: multi-byte counter reads, multi-byte delay writes, control-register writes.
- Sits between a valid/ready command source and the shared PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA bus.

Parameters:
- ADDR_BITS, 12, width of PADDR and cmd_addr.
- DATA_BITS, 8, width of PWDATA/PRDATA (one beat).
- MAX_BEATS, 8, maximum beats per burst; cmd_wdata/rsp_rdata are DATA_BITS*MAX_BEATS wide.
- CNT_BITS, 3, width of cmd_count; must equal clog2(MAX_BEATS).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready at a rising edge.
- cmd_write  input  1  1=write burst, 0=read burst.
- cmd_addr  input  ADDR_BITS  address of beat 0.
- cmd_count  input  CNT_BITS  number of beats minus 1 (0 => 1 beat, 7 => 8 beats).
- cmd_wdata  input  DATA_BITS*MAX_BEATS  beat k data in [k*DATA_BITS +: DATA_BITS].
- rsp_valid  output  1  one-cycle pulse on burst completion (reads and writes).
- rsp_rdata  output  DATA_BITS*MAX_BEATS  read data; beat k in [k*DATA_BITS +: DATA_BITS].
- busy  output  1  high from the cycle after acceptance until the final ACCESS cycle, inclusive.
- PADDR  output  ADDR_BITS  APB2 address.
- PSEL  output  1  APB2 select.
- PENABLE  output  1  APB2 enable.
- PWRITE  output  1  APB2 direction.
- PWDATA  output  DATA_BITS  APB2 write data.
- PRDATA  input  DATA_BITS  APB2 read data.

Behaviour:
- Reset (rst=0, async, overrides any transfer): state IDLE; PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, busy=0, cmd_ready=1 once rst=1. Burst in flight is abandoned; no rsp_valid.
- All outputs registered except cmd_ready (decoded from state).
- FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP on accept. Latch cmd_write, cmd_count, cmd_wdata; beat index = 0. Drive PSEL=1, PENABLE=0, PADDR=cmd_addr, PWRITE=cmd_write, PWDATA=beat 0 (write) or hold previous (read).
- SETUP -> ACCESS unconditionally: PENABLE=1; PSEL/PADDR/PWRITE/PWDATA stable.
- ACCESS exit edge: for reads, capture PRDATA into beat slot of an internal read buffer.
  - If beat index < count: -> SETUP, PENABLE=0, PSEL stays 1, PADDR+1, PWDATA=next beat, beat index+1.
  - Else: -> IDLE, PSEL=PENABLE=0, rsp_valid=1 for exactly one cycle.
- No PREADY: every beat is exactly 2 cycles. A burst of N beats occupies 2N cycles from the first SETUP; rsp_valid is high in cycle 2N+1 after acceptance edge.
- Read response:
  - rsp_rdata = read buffer; unused upper beats are 0.
  - Updates only at the rsp_valid edge and holds until the next read response.
  - Write bursts pulse rsp_valid but leave rsp_rdata unchanged.
- Read buffer is cleared to 0 on read-command acceptance.
- Address arithmetic is modulo 2^ADDR_BITS: 0xFFF+1 -> 0x000 with ADDR_BITS=12.
- In IDLE, PADDR/PWRITE/PWDATA hold their last values; PSEL=PENABLE=0.
- Back-to-back: cmd_ready=1 in the rsp_valid cycle; a command accepted then starts SETUP next cycle, giving a single idle bus cycle between bursts.
- cmd_* inputs are ignored outside IDLE; changes mid-burst have no effect.

Test Plan:
- Reset values: hold rst=0 for 10 cycles -> PSEL=PENABLE=0, PADDR=0, rsp_valid=0, cmd_ready=1. Release -> still idle, no bus activity.
- Single write: write addr=0x010, count=0, wdata byte0=0x02 -> one SETUP (PSEL=1, PENABLE=0, PADDR=0x010, PWRITE=1, PWDATA=0x02), then ACCESS, then rsp_valid pulse in cycle 3; timer slave ctrl reg reads back 0x02.
- 8-beat write: addr=0x008, count=7, wdata=64'd50 -> PADDR 0x008..0x00F, PWDATA 0x32 then 0x00x7, 16 bus cycles; slave count-down reg = 50.
- 8-beat read: memory slave holding bytes 0x11..0x88 at 0x000..0x007; addr=0, count=7 -> rsp_rdata=64'h8877665544332211 with rsp_valid on cycle 17.
- Short read and wrap: addr=0xFFE, count=2, memory 0xA1,0xB2,0xC3 at 0xFFE,0xFFF,0x000 -> PADDR sequence FFE,FFF,000; rsp_rdata=64'h0000000000C3B2A1.
- Reset mid-burst: assert rst=0 during beat 3 of an 8-beat read -> PSEL/PENABLE drop immediately; no rsp_valid. After release, cmd_ready=1; a new 1-beat read completes correctly.
- Back-to-back: hold cmd_valid with two commands -> second accepted in the first burst's rsp_valid cycle; exactly one PSEL=0 cycle between bursts.

Source files
------------

// File: rtl/apb2_burst_master.sv
// rtl/apb2_burst_master.sv - APB2 initiator turning one command into a burst of sequential byte transfers
module apb2_burst_master #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 8,
  parameter int MAX_BEATS = 8,
  parameter int CNT_BITS  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [ADDR_BITS-1:0]           cmd_addr,
  input  logic [CNT_BITS-1:0]            cmd_count,
  input  logic [DATA_BITS*MAX_BEATS-1:0] cmd_wdata,
  output logic                           rsp_valid,
  output logic [DATA_BITS*MAX_BEATS-1:0] rsp_rdata,
  output logic                           busy,
  output logic [ADDR_BITS-1:0]           PADDR,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [DATA_BITS-1:0]           PWDATA,
  input  logic [DATA_BITS-1:0]           PRDATA
);

  localparam int BUF_BITS = DATA_BITS * MAX_BEATS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_BITS-1:0]  beat;
  logic [CNT_BITS-1:0]  count;
  logic [BUF_BITS-1:0]  wbuf;
  logic [BUF_BITS-1:0]  rbuf;
  logic [BUF_BITS-1:0]  rbuf_merged;
  logic                 accept;
  logic                 last_beat;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign last_beat = (beat == count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = last_beat ? IDLE : SETUP;
      default: state_nxt = IDLE;
    endcase
  end

  // Read buffer with the beat currently on PRDATA folded in, so the final
  // beat lands in rsp_rdata on the same edge that raises rsp_valid.
  always_comb begin
    rbuf_merged = rbuf;
    rbuf_merged[int'(beat) * DATA_BITS +: DATA_BITS] = PRDATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rbuf      <= '0;
      wbuf      <= '0;
      beat      <= '0;
      count     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            busy    <= 1'b1;
            beat    <= '0;
            count   <= cmd_count;
            // Write data is kept as a shift register: beat 0 goes straight
            // onto PWDATA, the rest shifts down one beat per transfer.
            wbuf    <= cmd_wdata >> DATA_BITS;
            if (cmd_write) begin
              PWDATA <= cmd_wdata[DATA_BITS-1:0];
            end else begin
              rbuf <= '0;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          PENABLE <= 1'b0;
          if (!PWRITE) begin
            rbuf <= rbuf_merged;
          end
          if (!last_beat) begin
            PADDR <= PADDR + ADDR_BITS'(1);
            beat  <= beat + CNT_BITS'(1);
            if (PWRITE) begin
              PWDATA <= wbuf[DATA_BITS-1:0];
              wbuf   <= wbuf >> DATA_BITS;
            end
          end else begin
            PSEL      <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            if (!PWRITE) begin
              rsp_rdata <= rbuf_merged;
            end
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
